spkr_sample_sched: RTL
======================

// Module: spkr_sample_sched
// PURPOSE
// - Paces stereo audio samples from the EQ engine into the speaker PDM driver at a fixed sample rate.
// - Buffers early-arriving sample pairs in a small FIFO and issues one out_vld pulse per sample period.
// - Handles underrun (zero fill + refill), applies mute, and counts underrun events.
// - Sits between the EQ engine output and the speaker-driver vld/lft_chnnl/rght_chnnl inputs.
// PARAMETERS
// - DEPTH   4     FIFO depth in stereo pairs; power of 2, >=2
// - PERIOD  1024  clk cycles per sample period; >=4
// - START   2     fill level (pairs) required to leave IDLE; 1..DEPTH
// PORTS
// - clk           in   1   system clock
// - rst_n         in   1   asynchronous, active-low reset
// - in_vld        in   1   lft_in/rght_in hold a valid pair
// - in_rdy        out  1   FIFO can accept a pair (= !full)
// - lft_in        in   16  signed left sample
// - rght_in       in   16  signed right sample
// - mute          in   1   1 = drive zero samples (sample timing continues)
// - out_vld       out  1   1-cycle pulse per sample period, to the speaker-driver vld input
// - lft_out       out  16  signed left sample; held between pulses
// - rght_out      out  16  signed right sample; held between pulses
// - underrun_cnt  out  8   saturating count of underrun events
// - running       out  1   FSM in RUN
// BEHAVIOUR
// - Reset: FIFO empty, period counter 0, FSM IDLE.
//   - All outputs 0 except in_rdy = 1.
//   - Reset is asynchronous and mid-operation: FIFO contents discarded, counters cleared.
// - Write: a pair is pushed when in_vld && in_rdy at a clk edge.
//   - in_rdy is derived from the registered full flag only.
//   - A write is refused when full, even on a pop cycle.
// - Period counter: free-runs 0..PERIOD-1 and wraps to 0.
//   - tick is asserted when count == PERIOD-1.
//   - The counter never stops, so out_vld spacing is exactly PERIOD cycles.
// - Output: on each tick, lft_out/rght_out/out_vld are registered at that edge.
//   - out_vld is high for the one cycle after the tick cycle.
//   - Latency from tick to out_vld is one cycle.
// - FSM IDLE:
//   - Each tick outputs 0/0 with out_vld = 1; no pop.
//   - Goes to RUN on a tick when the fill level is >= START.
//   - That same tick pops and outputs the head pair.
// - FSM RUN:
//   - Each tick pops the head pair and outputs it.
//   - If the FIFO is empty at the tick: output 0/0 with out_vld = 1, increment underrun_cnt (saturates at 255), go to IDLE.
// - Simultaneous push and pop in one cycle: both occur, fill level unchanged.
//   - Pop data is the old head, never the pair being written.
// - Pointers: log2(DEPTH) bits each, wrap naturally.
//   - Fill level is a separate counter of log2(DEPTH)+1 bits.
//   - full = (level == DEPTH); empty = (level == 0).
// - Mute: sampled at the tick.
//   - When 1, output samples are 0 but pops, FSM and underrun accounting proceed unchanged.
// - No combinational path from any input to any output.
// CONFIGURATION
// - SPKR_SOFT_MUTE_EN defined:
//   - Adds a 5-bit gain register, reset 16, that steps by 1 per tick toward the target (0 if mute, else 16).
//   - Output = (sample * gain) >>> 4, computed as a 21-bit signed product and truncated to 16 bits.
//   - A full mute/unmute ramp therefore takes 16 ticks.
//   - Mute entry/exit is otherwise identical.
// - SPKR_SOFT_MUTE_EN undefined: mute is an immediate hard zero at the next tick, with no gain logic.
// TESTING
// - Reset checks: reset, release, no input.
//   - out_vld pulses every 1024 cycles with 0/0.
//   - running = 0, in_rdy = 1.
// - Normal flow: push 0x1234/0xFEDC and 0x0001/0x8000 before a tick.
//   - The next tick enters RUN and outputs 0x1234/0xFEDC.
//   - The following tick outputs 0x0001/0x8000.
// - Full flag: push 4 pairs with no tick.
//   - in_rdy falls after the 4th write; a 5th in_vld is ignored.
//   - After one tick, in_rdy = 1.
// - Push and pop together: hold in_vld with the FIFO at level 3 across a tick.
//   - Level stays 3 and the popped pair is the oldest.
// - Underrun: stop input in RUN until the FIFO drains.
//   - The next tick outputs 0/0, underrun_cnt = 1, running = 0.
//   - 300 underruns saturate the count at 255.
// - Mute:
//   - With SPKR_SOFT_MUTE_EN undefined, mute = 1 with samples 0x4000 gives 0 at the next tick.
//   - With SPKR_SOFT_MUTE_EN defined, the same stimulus outputs 0x3C00, 0x3800, ..., reaching 0 after 16 ticks.
//   - Asserting rst_n low mid-ramp clears everything and restores gain to 16.

Source files
------------

// File: rtl/spkr_sample_sched.sv
// Paces stereo sample pairs from the EQ engine into the speaker PDM driver.
// Optional ramped mute when SPKR_SOFT_MUTE_EN is defined; hard mute otherwise.
module spkr_sample_sched #(
    parameter int DEPTH  = 4,
    parameter int PERIOD = 1024,
    parameter int START  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [15:0] lft_in,
    input  logic [15:0] rght_in,
    input  logic        mute,
    output logic        out_vld,
    output logic [15:0] lft_out,
    output logic [15:0] rght_out,
    output logic [7:0]  underrun_cnt,
    output logic        running
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(PERIOD);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nxt;

    logic [15:0]   lft_mem  [DEPTH];
    logic [15:0]   rght_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [CW-1:0] cnt;

    logic tick;
    logic full;
    logic empty;
    logic start_ok;
    logic push;
    logic pop;
    logic underrun;
    logic [15:0] smp_l;
    logic [15:0] smp_r;

    assign tick     = (cnt == CW'(PERIOD - 1));
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign start_ok = (level >= LW'(START));
    assign in_rdy   = ~full;
    assign push     = in_vld & ~full;
    assign running  = (state == RUN);

    // Free-running period counter; never gated so pulses stay evenly spaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            lft_mem[wr_ptr]  <= lft_in;
            rght_mem[wr_ptr] <= rght_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (push && !pop): level <= level + 1'b1;
                (pop && !push): level <= level - 1'b1;
                default:        level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (tick && start_ok) state_nxt = RUN;
            RUN:  if (tick && empty)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        underrun = 1'b0;
        unique case (state)
            IDLE: pop = tick & start_ok;
            RUN: begin
                pop      = tick & ~empty;
                underrun = tick & empty;
            end
            default: begin
                pop      = 1'b0;
                underrun = 1'b0;
            end
        endcase
    end

`ifdef SPKR_SOFT_MUTE_EN
    logic [4:0] gain;
    logic [4:0] gain_nxt;

    function automatic logic [15:0] scale(input logic [15:0] s,
                                          input logic [4:0]  g);
        logic signed [20:0] p;
        p = $signed({{5{s[15]}}, s}) * $signed({16'd0, g});
        return p[19:4];
    endfunction

    always_comb begin
        gain_nxt = gain;
        if (mute && gain != 5'd0) begin
            gain_nxt = gain - 1'b1;
        end else if (!mute && gain != 5'd16) begin
            gain_nxt = gain + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gain <= 5'd16;
        end else if (tick) begin
            gain <= gain_nxt;
        end
    end

    // The new gain applies to the sample leaving on this same tick.
    assign smp_l = pop ? scale(lft_mem[rd_ptr], gain_nxt)  : 16'd0;
    assign smp_r = pop ? scale(rght_mem[rd_ptr], gain_nxt) : 16'd0;
`else
    assign smp_l = (pop && !mute) ? lft_mem[rd_ptr]  : 16'd0;
    assign smp_r = (pop && !mute) ? rght_mem[rd_ptr] : 16'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            lft_out  <= '0;
            rght_out <= '0;
        end else begin
            out_vld <= tick;
            if (tick) begin
                lft_out  <= smp_l;
                rght_out <= smp_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun_cnt <= '0;
        end else if (underrun && underrun_cnt != 8'hFF) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule
